// File: rtl/seg_display_scheduler_pkg.sv
// seg_pkg: shared types and helpers for the seven-segment display scheduler.
//   seg_t          active-low segment vector {g,f,e,d,c,b,a}
//   SEG_BLANK      all segments off
//   hex_to_seg     hex nibble -> active-low segment pattern (0-F)
//   sched_state_t  scheduler FSM states (BLANK / ON)
package seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  typedef enum logic {
    BLANK = 1'b0,
    ON    = 1'b1
  } sched_state_t;

  function automatic seg_t hex_to_seg(input logic [3:0] hex);
    seg_t s;
    case (hex)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg_display_scheduler_if.sv
// seg_display_scheduler_if: pin-side bundle of the display scheduler.
//   digit_vals   hex nibble per digit, digit i = [4i+3:4i]
//   digit_en     per-digit rotation enable
//   anode_n      active-low digit drive
//   seg          active-low segments {g,f,e,d,c,b,a}
//   active_idx   index of digit currently lit / last selected
//   frame_start  one-cycle pulse when rotation wraps
// Modports: master = nibble/enable source, slave = scheduler.
interface seg_display_scheduler_if #(
  parameter int unsigned N_DIGITS = 2
);
  import seg_pkg::*;

  localparam int unsigned IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic [4*N_DIGITS-1:0] digit_vals;
  logic [N_DIGITS-1:0]   digit_en;
  logic [N_DIGITS-1:0]   anode_n;
  seg_t                  seg;
  logic [IW-1:0]         active_idx;
  logic                  frame_start;

  modport master (
    output digit_vals, digit_en,
    input  anode_n, seg, active_idx, frame_start
  );

  modport slave (
    input  digit_vals, digit_en,
    output anode_n, seg, active_idx, frame_start
  );

endinterface

// File: rtl/seg_display_scheduler_decoder.sv
// seven_seg_decoder: combinational hex -> active-low seven-segment decoder.
//   hex  in   4  nibble to display
//   seg  out  7  active-low segments {g,f,e,d,c,b,a}
module seven_seg_decoder
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output seg_t       seg
);

  assign seg = hex_to_seg(hex);

endmodule

// File: rtl/seg_display_scheduler.sv
// seg_display_scheduler: round-robin ON/BLANK multiplexer driving N_DIGITS
// common-anode digits through one shared decoder.
//   clk    in  system clock, posedge
//   reset  in  synchronous, active-low reset
//   bus    slave modport: digit_vals/digit_en in; anode_n/seg/active_idx/
//          frame_start out (all outputs registered)
// Each visit: BLANK_CYCLES with all anodes off, then REFRESH_CYCLES with one
// anode low. The digit's nibble is captured at turn-on and held for the visit.
module seg_display_scheduler
  import seg_pkg::*;
#(
  parameter int unsigned N_DIGITS       = 2,
  parameter int unsigned REFRESH_CYCLES = 4000,
  parameter int unsigned BLANK_CYCLES   = 40
) (
  input logic                   clk,
  input logic                   reset,
  seg_display_scheduler_if.slave bus
);

  localparam int unsigned MAXC = (REFRESH_CYCLES > BLANK_CYCLES) ? REFRESH_CYCLES : BLANK_CYCLES;
  localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int unsigned IW   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [CW-1:0] BLANK_LAST   = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] REFRESH_LAST = CW'(REFRESH_CYCLES - 1);
  localparam logic [IW-1:0] IDX_RESET    = IW'(N_DIGITS - 1);

  sched_state_t          state;
  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [3:0]            snapshot;
  logic [N_DIGITS-1:0]   anode_n_q;
  seg_t                  seg_q;
  logic                  frame_start_q;

  logic                  found;
  logic [IW-1:0]         nxt;
  logic [N_DIGITS-1:0]   nxt_onehot;
  logic [3:0]            dec_nibble;
  seg_t                  dec_seg;

  // Circular search starting at idx+1. Offsets are scanned from largest to
  // smallest so the nearest enabled digit is the last (winning) assignment;
  // offset N_DIGITS lands on idx itself, giving the single-digit reselect.
  always_comb begin
    found = 1'b0;
    nxt   = idx;
    for (int unsigned k = N_DIGITS; k >= 1; k--) begin
      int unsigned pos;
      pos = (32'(idx) + k) % N_DIGITS;
      if (bus.digit_en[pos]) begin
        found = 1'b1;
        nxt   = pos[IW-1:0];
      end
    end
  end

  always_comb begin
    nxt_onehot      = '0;
    nxt_onehot[nxt] = 1'b1;
  end

  // Snapshot mux: while blanking, the decoder previews the candidate digit so
  // anode and seg load on the same edge; while lit, it sees the held nibble.
  assign dec_nibble = (state == BLANK) ? bus.digit_vals[4*32'(nxt) +: 4] : snapshot;

  seven_seg_decoder u_decoder (
    .hex (dec_nibble),
    .seg (dec_seg)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= BLANK;
      cnt           <= '0;
      idx           <= IDX_RESET;
      snapshot      <= '0;
      anode_n_q     <= '1;
      seg_q         <= SEG_BLANK;
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      case (state)
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            cnt <= '0;
            if (found) begin
              state         <= ON;
              idx           <= nxt;
              snapshot      <= dec_nibble;
              anode_n_q     <= ~nxt_onehot;
              seg_q         <= dec_seg;
              frame_start_q <= (nxt <= idx);
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ON: begin
          if (cnt == REFRESH_LAST) begin
            state     <= BLANK;
            cnt       <= '0;
            anode_n_q <= '1;
            seg_q     <= SEG_BLANK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state     <= BLANK;
          cnt       <= '0;
          anode_n_q <= '1;
          seg_q     <= SEG_BLANK;
        end
      endcase
    end
  end

  assign bus.anode_n     = anode_n_q;
  assign bus.seg         = seg_q;
  assign bus.active_idx  = idx;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_display_scheduler.sv
module tb_seg_display_scheduler;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  seg_display_scheduler_if #(.N_DIGITS(2)) bus ();

  seg_display_scheduler #(
    .N_DIGITS       (2),
    .REFRESH_CYCLES (4),
    .BLANK_CYCLES   (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, act, exp);
    end
  endtask

  // Advance one edge, then compare every output against hand-computed values.
  task automatic step(input string tag, input logic [1:0] an, input logic [6:0] sg,
                      input logic fs, input logic idx);
    @(posedge clk);
    #1;
    check({tag, ".anode"}, 32'(bus.anode_n), 32'(an));
    check({tag, ".seg"}, 32'(bus.seg), 32'(sg));
    check({tag, ".fs"}, 32'(bus.frame_start), 32'(fs));
    check({tag, ".idx"}, 32'(bus.active_idx), 32'(idx));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    bus.digit_en   = 2'b11;
    bus.digit_vals = 8'h3A;

    // 1: reset held for three edges
    for (int i = 0; i < 3; i++) step("rst", 2'b11, 7'h7F, 1'b0, 1'b1);

    // 2: release; first ON at digit 0 after one blank cycle
    reset = 1'b1;
    step("r2_on0", 2'b10, 7'h08, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step("r2_on0", 2'b10, 7'h08, 1'b0, 1'b0);
    step("r2_blk", 2'b11, 7'h7F, 1'b0, 1'b0);
    step("r2_on1", 2'b01, 7'h30, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step("r2_on1", 2'b01, 7'h30, 1'b0, 1'b1);
    step("r2_blk", 2'b11, 7'h7F, 1'b0, 1'b1);
    step("r2_wrap", 2'b10, 7'h08, 1'b1, 1'b0);

    // 3: nibble change mid-visit is held off until next visit
    step("r3_on0", 2'b10, 7'h08, 1'b0, 1'b0);
    bus.digit_vals = 8'h35;
    for (int i = 0; i < 2; i++) step("r3_hold", 2'b10, 7'h08, 1'b0, 1'b0);
    step("r3_blk", 2'b11, 7'h7F, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step("r3_on1", 2'b01, 7'h30, 1'b0, 1'b1);
    step("r3_blk", 2'b11, 7'h7F, 1'b0, 1'b1);
    step("r3_new", 2'b10, 7'h12, 1'b1, 1'b0);

    // 4: digit 0 disabled while lit; visit completes, then only digit 1
    bus.digit_en = 2'b10;
    for (int i = 0; i < 3; i++) step("r4_finish", 2'b10, 7'h12, 1'b0, 1'b0);
    step("r4_blk", 2'b11, 7'h7F, 1'b0, 1'b0);
    step("r4_on1", 2'b01, 7'h30, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step("r4_on1", 2'b01, 7'h30, 1'b0, 1'b1);
    for (int r = 0; r < 2; r++) begin
      step("r4_blk", 2'b11, 7'h7F, 1'b0, 1'b1);
      step("r4_resel", 2'b01, 7'h30, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) step("r4_on1", 2'b01, 7'h30, 1'b0, 1'b1);
    end

    // 5: nothing enabled -> stays dark; then digit 0 lights next expiry
    bus.digit_en = 2'b00;
    for (int i = 0; i < 20; i++) step("r5_dark", 2'b11, 7'h7F, 1'b0, 1'b1);
    bus.digit_en = 2'b01;
    step("r5_on0", 2'b10, 7'h12, 1'b1, 1'b0);

    // 6: reset mid-visit blanks at the next edge, restart at digit 0
    step("r6_on0", 2'b10, 7'h12, 1'b0, 1'b0);
    reset = 1'b0;
    step("r6_rst", 2'b11, 7'h7F, 1'b0, 1'b1);
    reset = 1'b1;
    bus.digit_en = 2'b11;
    step("r6_restart", 2'b10, 7'h12, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
